// File: rtl/npc_core_mc.sv
// Multi-cycle RV32I-subset core (addi/add/sub/lui/auipc/jal/jalr/ebreak) with a req/valid fetch port.
// Define NPC_ILLEGAL_TRAP_EN to halt on unsupported encodings; otherwise they execute as nops.
module npc_core_mc #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            retire,
  output logic            halt,
  output logic [XLEN-1:0] halt_code
);

  localparam int unsigned RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [6:0]  OP_IMM      = 7'b0010011;
  localparam logic [6:0]  OP_REG      = 7'b0110011;
  localparam logic [6:0]  OP_LUI      = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC    = 7'b0010111;
  localparam logic [6:0]  OP_JAL      = 7'b1101111;
  localparam logic [6:0]  OP_JALR     = 7'b1100111;
  localparam logic [6:0]  OP_SYSTEM   = 7'b1110011;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_e;

  state_e                 state_q, state_d;
  logic                   req_q, req_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [31:0]            inst_q, inst_d;
  logic signed [XLEN-1:0] result_q, result_d;
  logic                   ovf_q, ovf_d;
  logic                   retire_q, retire_d;
  logic                   halt_q, halt_d;
  logic [XLEN-1:0]        halt_code_q, halt_code_d;

  logic [XLEN-1:0]        rf_q [NREG];
  logic                   rf_we;
  logic [RIDX_W-1:0]      rf_waddr;
  logic [XLEN-1:0]        rf_wdata;

  function automatic logic idx_ok(input logic [4:0] idx);
    return 32'(idx) < NREG;
  endfunction

  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic add_ovf(input logic signed [XLEN-1:0] a,
                                   input logic signed [XLEN-1:0] b,
                                   input logic signed [XLEN-1:0] s);
    return (a[XLEN-1] == b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [XLEN-1:0] a,
                                   input logic signed [XLEN-1:0] b,
                                   input logic signed [XLEN-1:0] s);
    return (a[XLEN-1] != b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);
  endfunction

  // Instruction fields and immediates of the latched instruction
  logic [6:0]             opcode;
  logic [4:0]             rd, rs1, rs2;
  logic [2:0]             funct3;
  logic [6:0]             funct7;
  logic signed [31:0]     imm_i32, imm_u32, imm_j32;
  logic signed [XLEN-1:0] imm_i, imm_u, imm_j;

  assign opcode  = inst_q[6:0];
  assign rd      = inst_q[11:7];
  assign funct3  = inst_q[14:12];
  assign rs1     = inst_q[19:15];
  assign rs2     = inst_q[24:20];
  assign funct7  = inst_q[31:25];
  assign imm_i32 = {{20{inst_q[31]}}, inst_q[31:20]};
  assign imm_u32 = {inst_q[31:12], 12'b0};
  assign imm_j32 = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
  assign imm_i   = sext32(imm_i32);
  assign imm_u   = sext32(imm_u32);
  assign imm_j   = sext32(imm_j32);

  // Register reads: x0 and out-of-range indices read as zero
  logic signed [XLEN-1:0] rs1_val, rs2_val, a0_val;

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0 && idx_ok(rs1)) rs1_val = rf_q[rs1[RIDX_W-1:0]];
    if (rs2 != 5'd0 && idx_ok(rs2)) rs2_val = rf_q[rs2[RIDX_W-1:0]];
  end

  assign a0_val = rf_q[RIDX_W'(10)];

  // Decode and ALU
  logic                   legal, idx_bad, illegal, is_ebreak, wr_en, uses_rs1, uses_rs2;
  logic signed [XLEN-1:0] alu_res;
  logic                   alu_ovf;
  logic [XLEN-1:0]        next_pc;

  always_comb begin
    legal     = 1'b1;
    is_ebreak = 1'b0;
    wr_en     = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    alu_res   = '0;
    alu_ovf   = 1'b0;
    next_pc   = pc_q + XLEN'(4);
    case (opcode)
      OP_IMM: begin
        if (funct3 == 3'b000) begin
          uses_rs1 = 1'b1;
          wr_en    = 1'b1;
          alu_res  = rs1_val + imm_i;
          alu_ovf  = add_ovf(rs1_val, imm_i, alu_res);
        end else begin
          legal = 1'b0;
        end
      end
      OP_REG: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
          wr_en   = 1'b1;
          alu_res = rs1_val + rs2_val;
          alu_ovf = add_ovf(rs1_val, rs2_val, alu_res);
        end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
          wr_en   = 1'b1;
          alu_res = rs1_val - rs2_val;
          alu_ovf = sub_ovf(rs1_val, rs2_val, alu_res);
        end else begin
          legal = 1'b0;
        end
      end
      OP_LUI: begin
        wr_en   = 1'b1;
        alu_res = imm_u;
      end
      OP_AUIPC: begin
        wr_en   = 1'b1;
        alu_res = signed'(pc_q) + imm_u;
      end
      OP_JAL: begin
        wr_en   = 1'b1;
        alu_res = signed'(pc_q + XLEN'(4));
        next_pc = pc_q + $unsigned(imm_j);
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          uses_rs1 = 1'b1;
          wr_en    = 1'b1;
          alu_res  = signed'(pc_q + XLEN'(4));
          next_pc  = $unsigned(rs1_val + imm_i) & ~XLEN'(1);
        end else begin
          legal = 1'b0;
        end
      end
      OP_SYSTEM: begin
        if (inst_q == INST_EBREAK) is_ebreak = 1'b1;
        else                       legal     = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    idx_bad = (uses_rs1 && !idx_ok(rs1)) || (uses_rs2 && !idx_ok(rs2)) ||
              (wr_en && !idx_ok(rd));
`ifdef NPC_ILLEGAL_TRAP_EN
    illegal = !legal || idx_bad;
`else
    illegal = !legal;
`endif
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    retire_d    = 1'b0;
    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    rf_we       = 1'b0;
    rf_waddr    = rd[RIDX_W-1:0];
    rf_wdata    = alu_res;
    case (state_q)
      S_FETCH: begin
        req_d = 1'b1;
        if (req_q && imem_valid) begin
          inst_d  = imem_inst;
          state_d = S_EXEC;
          req_d   = 1'b0;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        req_d   = 1'b1;
        if (is_ebreak) begin
          state_d     = S_HALT;
          req_d       = 1'b0;
          halt_d      = 1'b1;
          halt_code_d = a0_val;
          retire_d    = 1'b1;
        end else if (illegal) begin
`ifdef NPC_ILLEGAL_TRAP_EN
          state_d     = S_HALT;
          req_d       = 1'b0;
          halt_d      = 1'b1;
          halt_code_d = '1;
`else
          pc_d     = pc_q + XLEN'(4);
          result_d = '0;
          ovf_d    = 1'b0;
          retire_d = 1'b1;
`endif
        end else begin
          pc_d     = next_pc;
          result_d = alu_res;
          ovf_d    = alu_ovf;
          retire_d = 1'b1;
          rf_we    = wr_en && (rd != 5'd0) && idx_ok(rd);
        end
      end
      S_HALT: req_d = 1'b0;
      default: begin
        state_d = S_FETCH;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_FETCH;
      req_q       <= 1'b0;
      pc_q        <= RESET_PC;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      retire_q    <= 1'b0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      pc_q        <= pc_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      retire_q    <= retire_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
    end
  end

  // The latched instruction is only consumed in EXEC, so it needs no reset
  always_ff @(posedge clk) begin
    inst_q <= inst_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign retire    = retire_q;
  assign halt      = halt_q;
  assign halt_code = halt_code_q;

endmodule

// File: tb/tb_npc_core_mc.sv
// Directed table-driven bench for npc_core_mc: program table plus reset, wait-state and halt sequences.
module tb_npc_core_mc;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_inst;
  logic [31:0] pc;
  logic [31:0] result;
  logic        overflow;
  logic        retire;
  logic        halt;
  logic [31:0] halt_code;

  int checks = 0;
  int errors = 0;

  npc_core_mc #(
    .XLEN(32),
    .NREG(32),
    .RESET_PC(32'h8000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_valid(imem_valid),
    .imem_inst(imem_inst),
    .pc(pc),
    .result(result),
    .overflow(overflow),
    .retire(retire),
    .halt(halt),
    .halt_code(halt_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    int          wt;
    logic [31:0] res;
    logic        ovf;
    logic [31:0] npc;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Present one instruction after wt idle cycles; returns at the negedge after EXEC
  task automatic fetch_exec(input logic [31:0] inst, input int wt, input logic [31:0] exp_addr);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'b0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, exp_addr);
    for (int i = 0; i < wt; i++) begin
      @(negedge clk);
      check("addr_hold", imem_addr, exp_addr);
      check("no_retire_wait", {31'b0, retire}, 32'd0);
    end
    imem_valid = 1'b1;
    imem_inst  = inst;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_inst  = 32'h0000_0013;
    check("exec_req_low", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] addr;

    vecs[0]  = '{32'h0050_0093, 0, 32'h0000_0005, 1'b0, 32'h8000_0004}; // addi x1,x0,5
    vecs[1]  = '{32'h8000_00b7, 0, 32'h8000_0000, 1'b0, 32'h8000_0008}; // lui x1,0x80000
    vecs[2]  = '{32'hfff0_8093, 0, 32'h7FFF_FFFF, 1'b1, 32'h8000_000C}; // addi x1,x1,-1
    vecs[3]  = '{32'h0010_8133, 0, 32'hFFFF_FFFE, 1'b1, 32'h8000_0010}; // add x2,x1,x1
    vecs[4]  = '{32'h4011_01B3, 2, 32'h7FFF_FFFF, 1'b1, 32'h8000_0014}; // sub x3,x2,x1
    vecs[5]  = '{32'h4031_8233, 0, 32'h0000_0000, 1'b0, 32'h8000_0018}; // sub x4,x3,x3
    vecs[6]  = '{32'h0000_1297, 0, 32'h8000_1018, 1'b0, 32'h8000_001C}; // auipc x5,1
    vecs[7]  = '{32'h0070_0013, 0, 32'h0000_0007, 1'b0, 32'h8000_0020}; // addi x0,x0,7
    vecs[8]  = '{32'h0010_0333, 0, 32'h7FFF_FFFF, 1'b0, 32'h8000_0024}; // add x6,x0,x1
    vecs[9]  = '{32'h0042_8293, 0, 32'h8000_101C, 1'b0, 32'h8000_0028}; // addi x5,x5,4
    vecs[10] = '{32'h0080_00ef, 0, 32'h8000_002C, 1'b0, 32'h8000_0030}; // jal x1,8
    vecs[11] = '{32'hFF50_8467, 0, 32'h8000_0034, 1'b0, 32'h8000_0020}; // jalr x8,x1,-11

    rst        = 1'b0;
    imem_valid = 1'b0;
    imem_inst  = 32'h0000_0013;
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_halt", {31'b0, halt}, 32'd0);
    check("rst_retire", {31'b0, retire}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    check("rst_halt_code", halt_code, 32'd0);

    // Valid offered while req is still low must be ignored
    rst        = 1'b1;
    imem_valid = 1'b1;
    imem_inst  = 32'h0050_0093;
    @(negedge clk);
    imem_valid = 1'b0;
    check("req_after_release", {31'b0, imem_req}, 32'd1);
    check("pc_after_release", pc, 32'h8000_0000);

    addr = 32'h8000_0000;
    for (int k = 0; k < 12; k++) begin
      fetch_exec(vecs[k].inst, vecs[k].wt, addr);
      check("retire", {31'b0, retire}, 32'd1);
      check("result", result, vecs[k].res);
      check("overflow", {31'b0, overflow}, {31'b0, vecs[k].ovf});
      check("pc", pc, vecs[k].npc);
      check("halt_low", {31'b0, halt}, 32'd0);
      addr = vecs[k].npc;
    end

    // Reset in the middle of a stalled fetch
    while (imem_req !== 1'b1) @(negedge clk);
    repeat (2) begin
      @(negedge clk);
      check("midwait_addr", imem_addr, 32'h8000_0020);
    end
    rst = 1'b0;
    @(negedge clk);
    check("midrst_pc", pc, 32'h8000_0000);
    check("midrst_req", {31'b0, imem_req}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_retire", {31'b0, retire}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_req_release", {31'b0, imem_req}, 32'd1);

    // Registers cleared by reset: x6 = x0 + x1 must be zero
    fetch_exec(32'h0010_0333, 0, 32'h8000_0000);
    check("post_rst_result", result, 32'd0);
    check("post_rst_retire", {31'b0, retire}, 32'd1);
    @(negedge clk);
    check("retire_single_pulse", {31'b0, retire}, 32'd0);

    fetch_exec(32'h0550_0513, 0, 32'h8000_0004); // addi x10,x0,0x55
    check("a0_result", result, 32'h0000_0055);

    fetch_exec(32'hFFFF_FFFF, 0, 32'h8000_0008);
`ifdef NPC_ILLEGAL_TRAP_EN
    check("ill_retire", {31'b0, retire}, 32'd0);
    check("ill_halt", {31'b0, halt}, 32'd1);
    check("ill_halt_code", halt_code, 32'hFFFF_FFFF);
    check("ill_req", {31'b0, imem_req}, 32'd0);
    check("ill_pc", pc, 32'h8000_0008);
`else
    check("nop_retire", {31'b0, retire}, 32'd1);
    check("nop_result", result, 32'd0);
    check("nop_ovf", {31'b0, overflow}, 32'd0);
    check("nop_pc", pc, 32'h8000_000C);
    check("nop_halt", {31'b0, halt}, 32'd0);

    fetch_exec(32'h0010_0073, 0, 32'h8000_000C); // ebreak
    check("ebreak_retire", {31'b0, retire}, 32'd1);
    check("ebreak_halt", {31'b0, halt}, 32'd1);
    check("ebreak_halt_code", halt_code, 32'h0000_0055);
    check("ebreak_pc", pc, 32'h8000_000C);
    check("ebreak_req", {31'b0, imem_req}, 32'd0);
`endif

    // Halt is absorbing: memory offers are ignored and nothing retires
    imem_valid = 1'b1;
    imem_inst  = 32'h0050_0093;
    repeat (3) begin
      @(negedge clk);
      check("halt_req_low", {31'b0, imem_req}, 32'd0);
      check("halt_no_retire", {31'b0, retire}, 32'd0);
      check("halt_sticky", {31'b0, halt}, 32'd1);
    end
    imem_valid = 1'b0;
`ifdef NPC_ILLEGAL_TRAP_EN
    check("halt_pc_hold", pc, 32'h8000_0008);
`else
    check("halt_pc_hold", pc, 32'h8000_000C);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
